// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared constants for the two-source round-robin mux front end.
//   SEL_A / SEL_B  : encoding of the select tag (and of last_grant)
//   DEFAULT_WIDTH  : default data width of each producer channel
//   NUM_SRC        : number of producer channels feeding the mux
// -----------------------------------------------------------------------------
package mux_pkg;

    localparam logic SEL_A         = 1'b0;
    localparam logic SEL_B         = 1'b1;
    localparam int   DEFAULT_WIDTH = 2;
    localparam int   NUM_SRC       = 2;

    // Convert a one-hot (or zero) two-way grant vector to a select tag.
    // A zero vector maps to SEL_A; callers qualify with "any grant".
    function automatic logic gnt_to_sel(input logic [1:0] gnt);
        return gnt[1] ? SEL_B : SEL_A;
    endfunction

endpackage : mux_pkg

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Purely combinational two-way round-robin grant.
//   req[1:0]    : request vector, bit 0 = source A, bit 1 = source B
//   last_grant  : source that won the most recent transfer (SEL_A / SEL_B)
//   gnt[1:0]    : one-hot grant, or all zero when nothing requests
// A lone requester always wins. On contention the source that did not win
// last time is granted.
// -----------------------------------------------------------------------------
module rr_arb2
    import mux_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_gnt
            // Source gi wins when it requests and either the other source is
            // idle or the other source was the previous winner.
            assign gnt[gi] = req[gi] & (~req[1-gi] | (last_grant != 1'(gi)));
        end
    endgenerate

endmodule : rr_arb2

// File: rtl/rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter
// Two-source valid/ready front end for the 2:1 datapath mux. Arbitrates between
// channels A and B with round-robin priority, registers the winning word and
// its select tag, and presents them downstream with one cycle of latency and
// full 1 word/cycle throughput.
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   a_valid  : channel A has a word          a_data : channel A word
//   a_ready  : channel A word accepted this cycle
//   b_valid  : channel B has a word          b_data : channel B word
//   b_ready  : channel B word accepted this cycle
//   q_valid  : output register holds a word
//   q_data   : selected word
//   sel      : source of held word (0 = A, 1 = B)
//   q_ready  : downstream consumes q this cycle
// -----------------------------------------------------------------------------
module rr_mux_arbiter
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data,
    output logic             sel,
    input  logic             q_ready
);

    // Output register and arbitration history.
    logic             q_valid_reg, q_valid_next;
    logic [WIDTH-1:0] q_data_reg,  q_data_next;
    logic             sel_reg,     sel_next;
    logic             last_grant_reg, last_grant_next;

    logic             load;
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             any_gnt;
    logic             gnt_sel;
    logic [WIDTH-1:0] src_data [NUM_SRC];

    assign req         = {b_valid, a_valid};
    assign src_data[0] = a_data;
    assign src_data[1] = b_data;

    rr_arb2 u_arb (
        .req        (req),
        .last_grant (last_grant_reg),
        .gnt        (gnt)
    );

    // The output register can take a word when it is empty or is being
    // drained this cycle, which lets consume and refill share one edge.
    assign load    = ~q_valid_reg | q_ready;
    assign any_gnt = |gnt;
    assign gnt_sel = gnt_to_sel(gnt);

    // Ready depends on valid through the grant; at most one is high since
    // the arbiter grant is one-hot or zero.
    assign a_ready = load & gnt[0];
    assign b_ready = load & gnt[1];

    always_comb begin
        q_valid_next    = q_valid_reg;
        q_data_next     = q_data_reg;
        sel_next        = sel_reg;
        last_grant_next = last_grant_reg;
        if (load) begin
            if (any_gnt) begin
                q_valid_next    = 1'b1;
                q_data_next     = src_data[gnt_sel];
                sel_next        = gnt_sel;
                last_grant_next = gnt_sel;
            end else begin
                // Emptied with nothing to refill: data and tag are stale
                // but kept to avoid needless toggling of the mux select.
                q_valid_next    = 1'b0;
            end
        end
    end

    // last_grant resets to B so that A wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid_reg    <= 1'b0;
            q_data_reg     <= '0;
            sel_reg        <= SEL_A;
            last_grant_reg <= SEL_B;
        end else begin
            q_valid_reg    <= q_valid_next;
            q_data_reg     <= q_data_next;
            sel_reg        <= sel_next;
            last_grant_reg <= last_grant_next;
        end
    end

    assign q_valid = q_valid_reg;
    assign q_data  = q_data_reg;
    assign sel     = sel_reg;

endmodule : rr_mux_arbiter

// File: tb/tb_rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_arbiter
// Self-checking bench for rr_mux_arbiter: directed scenarios followed by a
// randomized run, all compared against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_rr_mux_arbiter;

    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         a_valid = 1'b0;
    logic [W-1:0] a_data = '0;
    logic         a_ready;
    logic         b_valid = 1'b0;
    logic [W-1:0] b_data = '0;
    logic         b_ready;
    logic         q_valid;
    logic [W-1:0] q_data;
    logic         sel;
    logic         q_ready = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Reference model state: what the output register should hold and which
    // source won the latest transfer (0 = A, 1 = B).
    bit         m_valid;
    bit [W-1:0] m_data;
    bit         m_sel;
    bit         m_last;

    // Acceptance results of the latest cycle, used to keep producers stable.
    bit acc_a, acc_b;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .q_valid (q_valid),
        .q_data  (q_data),
        .sel     (sel),
        .q_ready (q_ready)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_data  = '0;
        m_sel   = 0;
        m_last  = 1;
    endtask

    // One clock cycle: apply inputs (called just after a falling edge), check
    // readies, let the rising edge happen, then check the output register.
    task automatic cycle(input bit av, input bit [W-1:0] ad,
                         input bit bv, input bit [W-1:0] bd, input bit qr);
        bit room;
        bit win_valid;
        bit winner;
        a_valid = av; a_data = ad;
        b_valid = bv; b_data = bd;
        q_ready = qr;
        #1;
        // The register has room if it is empty or its word leaves now.
        room = !m_valid || qr;
        win_valid = av || bv;
        if (av && bv)  winner = !m_last;   // alternate on contention
        else if (av)   winner = 0;
        else           winner = 1;
        acc_a = room && win_valid && winner == 0;
        acc_b = room && win_valid && winner == 1;
        check("a_ready", 8'(a_ready), 8'(acc_a));
        check("b_ready", 8'(b_ready), 8'(acc_b));
        @(posedge clk);
        if (room) begin
            if (win_valid) begin
                m_valid = 1;
                m_data  = winner ? bd : ad;
                m_sel   = winner;
                m_last  = winner;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        check("q_valid", 8'(q_valid), 8'(m_valid));
        check("q_data",  8'(q_data),  8'(m_data));
        check("sel",     8'(sel),     8'(m_sel));
        $display("cyc t=%0t av=%0b ad=%0h bv=%0b bd=%0h qr=%0b -> ar=%0b br=%0b qv=%0b qd=%0h sel=%0b",
                 $time, av, ad, bv, bd, qr, a_ready, b_ready, q_valid, q_data, sel);
        @(negedge clk);
    endtask

    initial begin
        bit         rav, rbv, rqr;
        bit [W-1:0] rad, rbd;

        // ---- Power-on reset ----
        model_reset();
        #3;
        check("por_q_valid", 8'(q_valid), 8'd0);
        check("por_q_data",  8'(q_data),  8'd0);
        check("por_sel",     8'(sel),     8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- Contention: expected 10,01,10,01 starting with A ----
        for (int i = 0; i < 4; i++) begin
            cycle(1, 2'b10, 1, 2'b01, 1);
            check("cont_sel_seq", 8'(sel), 8'(i % 2));
        end

        // ---- Single source B ----
        for (int i = 0; i < 3; i++) begin
            cycle(0, 2'b00, 1, 2'b11, 1);
            check("single_b_data", 8'(q_data), 8'h3);
        end

        // ---- Backpressure: load A then stall with both valid ----
        cycle(1, 2'b10, 0, 2'b00, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 2'b10, 1, 2'b01, 0);
            check("bp_hold_data", 8'(q_data), 8'h2);
        end
        cycle(1, 2'b10, 1, 2'b01, 1);
        check("bp_release_b", 8'(q_data), 8'h1);

        // ---- Drain ----
        cycle(0, 2'b00, 0, 2'b00, 1);
        cycle(0, 2'b00, 0, 2'b00, 1);
        check("drain_empty", 8'(q_valid), 8'd0);

        // ---- Reset mid-contention after a B grant ----
        cycle(1, 2'b10, 1, 2'b01, 1);   // A wins (last was B)
        cycle(1, 2'b10, 1, 2'b01, 1);   // B wins, q_valid = 1
        #2;
        rst_n = 1'b0;                   // asynchronous, away from any edge
        #1;
        model_reset();
        check("rst_async_q_valid", 8'(q_valid), 8'd0);
        check("rst_async_q_data",  8'(q_data),  8'd0);
        check("rst_async_sel",     8'(sel),     8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 2'b10, 1, 2'b01, 1);
        check("rst_first_grant_a", 8'(sel), 8'd0);

        // ---- Randomized traffic; producers hold a word until accepted ----
        rav = 0; rbv = 0; rad = '0; rbd = '0;
        acc_a = 0; acc_b = 0;
        for (int i = 0; i < 400; i++) begin
            if (!(rav && !acc_a)) begin
                rav = ($urandom_range(0, 3) != 0);
                rad = W'($urandom);
            end
            if (!(rbv && !acc_b)) begin
                rbv = ($urandom_range(0, 3) != 0);
                rbd = W'($urandom);
            end
            rqr = ($urandom_range(0, 3) != 0);
            cycle(rav, rad, rbv, rbd, rqr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rr_mux_arbiter
